rom_loader: RTL and testbench
=============================

// Module: rom_loader
// PURPOSE
//  Boot-time program loader placed upstream of the instruction ROM. Receives a
//  byte stream (valid/ready), assembles big-endian 32-bit instruction words,
//  writes them through the ROM write port and holds the MIPS core in reset.
//  Releases the core only after the whole image loads and its checksum matches.
// PARAMETERS
//  ADDR_WIDTH  32      width of mem_addr (byte address, matches instruction address bus)
//  DATA_WIDTH  32      width of mem_data (one instruction word)
//  BASE_ADDR   32'h0   byte address written by the first word
//  MAX_WORDS   1024    largest accepted image, in words
// PORTS
//  clock             in   1           rising-edge clock
//  reset             in   1           asynchronous, active-low reset
//  byte_valid        in   1           byte_data holds a valid byte
//  byte_data         in   8           stream byte
//  byte_ready        out  1           loader accepts a byte this cycle
//  mem_write_enable  out  1           ROM write strobe, one cycle per word
//  mem_addr          out  ADDR_WIDTH  ROM write byte address
//  mem_data          out  DATA_WIDTH  ROM write word
//  cpu_reset         out  1           active-high hold applied to the core's reset input
//  load_done         out  1           image loaded and checksum ok (sticky)
//  load_error        out  1           oversize image or bad checksum (sticky)
//  words_loaded      out  16          count of words written so far
// BEHAVIOUR
//  - Stream format: N_hi, N_lo (16-bit word count N), 4*N data bytes (MSB first),
//    then 1 checksum byte = XOR of every preceding byte, including the header.
//  - Byte accepted when byte_valid & byte_ready. All outputs are registered.
//  - Reset values: byte_ready=0, mem_write_enable=0, mem_addr=BASE_ADDR, mem_data=0,
//    cpu_reset=1, load_done=0, load_error=0, words_loaded=0. State resets to HDR_HI.
//  - byte_ready=1 from the first clock edge after reset deasserts, in HDR_HI/HDR_LO/DATA/CHECK.
//    It is 0 in DONE and ERROR.
//  - FSM: HDR_HI -> HDR_LO on accept. From HDR_LO on accept:
//    N>MAX_WORDS -> ERROR; N==0 -> CHECK; else -> DATA.
//  - DATA: 2-bit byte index shifts bytes into an assembly register.
//    On the 4th byte, the next cycle drives mem_write_enable=1 for exactly one cycle.
//    mem_addr = BASE_ADDR + 4*words_loaded; mem_data = assembled word.
//    words_loaded increments in that same cycle.
//    After the N-th word's 4th byte -> CHECK. The final write pulse may overlap the
//    CHECK accept cycle; both take effect.
//  - CHECK: on accept, compare the byte with the running XOR.
//    Equal -> DONE; else -> ERROR.
//  - DONE: load_done=1, cpu_reset=0 (next cycle after the check byte accept).
//  - ERROR: load_error=1, cpu_reset stays 1.
//  - DONE and ERROR are terminal until reset. Bytes offered there are ignored
//    (byte_ready=0).
//  - Reset asserted mid-load aborts immediately:
//    * all outputs return to reset values asynchronously;
//    * the partial image is not erased;
//    * a new load restarts from HDR_HI.
//  - byte_valid gaps of any length stall assembly without losing state.
//  - mem_addr wraps modulo 2^ADDR_WIDTH.
// TESTING
//  1. N=2, words 32'h3401_0001, 32'h0022_1820, correct checksum ->
//     writes at 0x0 and 0x4, words_loaded=2, load_done=1, cpu_reset=0.
//  2. N=0, checksum 8'h00 -> no write pulses; DONE one cycle after the check byte.
//  3. N=1 with checksum bit 0 flipped -> one write occurs, then load_error=1,
//     cpu_reset=1, byte_ready=0.
//  4. N=MAX_WORDS+1 header -> ERROR right after N_lo; no mem_write_enable pulses.
//  5. byte_valid toggled 1,0,0,1 within a word -> the word is assembled correctly;
//     exactly one write pulse per 4 accepted bytes.
//  6. reset low for 1 cycle after 3 data bytes, then a full valid N=1 image ->
//     all outputs return to reset values; the word is written at BASE_ADDR; load_done=1.

Source files
------------

// File: rtl/rom_loader.sv
// Boot loader: parses a [N_hi, N_lo, 4*N data bytes, XOR checksum] byte stream,
// writes big-endian words to the instruction ROM and releases the core on success.
module rom_loader #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    MAX_WORDS  = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  cpu_reset,
  output logic                  load_done,
  output logic                  load_error,
  output logic [15:0]           words_loaded
);

  typedef enum logic [2:0] {
    HDR_HI,
    HDR_LO,
    DATA,
    CHECK,
    DONE,
    ERROR
  } state_t;

  localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

  state_t                r_state;
  logic [15:0]           r_count;
  logic [1:0]            r_idx;
  logic [23:0]           r_asm;
  logic [7:0]            r_xor;
  logic                  r_ready;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_cpu_reset;
  logic                  r_done;
  logic                  r_error;
  logic [15:0]           r_words;

  logic                  w_accept;
  logic [15:0]           w_n;
  logic [31:0]           w_word;
  logic [15:0]           w_words_next;
  logic [ADDR_WIDTH-1:0] w_word_addr;

  assign w_accept     = byte_valid & r_ready;
  assign w_n          = {r_count[15:8], byte_data};
  assign w_word       = {r_asm, byte_data};
  assign w_words_next = r_words + 16'd1;
  // Address arithmetic is done at ADDR_WIDTH so it wraps naturally.
  assign w_word_addr  = BASE_ADDR + ADDR_WIDTH'({r_words, 2'b00});

  // NOTE: every register, datapath included, is cleared by the async reset so
  // that an aborted load leaves all outputs at their documented reset values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= HDR_HI;
      r_count     <= '0;
      r_idx       <= '0;
      r_asm       <= '0;
      r_xor       <= '0;
      r_ready     <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= BASE_ADDR;
      r_data      <= '0;
      r_cpu_reset <= 1'b1;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_words     <= '0;
    end else begin
      // NOTE: non-blocking defaults first; later assignments in the same pass
      // override them, so a terminal transition drops byte_ready in one edge.
      r_we    <= 1'b0;
      r_ready <= (r_state != DONE) && (r_state != ERROR);

      case (r_state)
        HDR_HI: begin
          if (w_accept) begin
            r_count[15:8] <= byte_data;
            r_xor         <= r_xor ^ byte_data;
            r_state       <= HDR_LO;
          end
        end

        HDR_LO: begin
          if (w_accept) begin
            r_count[7:0] <= byte_data;
            r_xor        <= r_xor ^ byte_data;
            r_idx        <= '0;
            if ({1'b0, w_n} > MAX_N) begin
              r_state <= ERROR;
              r_error <= 1'b1;
              r_ready <= 1'b0;
            end else if (w_n == 16'd0) begin
              r_state <= CHECK;
            end else begin
              r_state <= DATA;
            end
          end
        end

        DATA: begin
          if (w_accept) begin
            r_xor <= r_xor ^ byte_data;
            r_asm <= {r_asm[15:0], byte_data};
            r_idx <= r_idx + 2'd1;
            if (r_idx == 2'd3) begin
              r_we    <= 1'b1;
              r_addr  <= w_word_addr;
              r_data  <= DATA_WIDTH'(w_word);
              r_words <= w_words_next;
              if (w_words_next == r_count) r_state <= CHECK;
            end
          end
        end

        CHECK: begin
          if (w_accept) begin
            r_ready <= 1'b0;
            if (byte_data == r_xor) begin
              r_state     <= DONE;
              r_done      <= 1'b1;
              r_cpu_reset <= 1'b0;
            end else begin
              r_state <= ERROR;
              r_error <= 1'b1;
            end
          end
        end

        DONE, ERROR: r_ready <= 1'b0;

        default: begin
          r_state <= ERROR;
          r_error <= 1'b1;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign byte_ready       = r_ready;
  assign mem_write_enable = r_we;
  assign mem_addr         = r_addr;
  assign mem_data         = r_data;
  assign cpu_reset        = r_cpu_reset;
  assign load_done        = r_done;
  assign load_error       = r_error;
  assign words_loaded     = r_words;

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: table of whole-image loads plus hand-written
// sequences for the header boundary, byte_valid gaps and a mid-load reset.
module tb_rom_loader;

  localparam int MAX_WORDS = 1024;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready;
  logic        mem_write_enable;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        cpu_reset;
  logic        load_done;
  logic        load_error;
  logic [15:0] words_loaded;

  rom_loader #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .BASE_ADDR (32'h0),
    .MAX_WORDS (MAX_WORDS)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .byte_valid      (byte_valid),
    .byte_data       (byte_data),
    .byte_ready      (byte_ready),
    .mem_write_enable(mem_write_enable),
    .mem_addr        (mem_addr),
    .mem_data        (mem_data),
    .cpu_reset       (cpu_reset),
    .load_done       (load_done),
    .load_error      (load_error),
    .words_loaded    (words_loaded)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [15:0] n;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [7:0]  csum_flip;
    logic        exp_done;
    logic        exp_err;
    int          exp_words;
  } vec_t;

  vec_t        vecs[4];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  csum;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  // Write-port scoreboard: one entry per strobe, sampled mid-cycle.
  always @(negedge clock) begin
    if (mem_write_enable) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_data);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
    check({tag, "_we"},         32'(mem_write_enable), 32'd0);
    check({tag, "_mem_addr"},   mem_addr, 32'h0);
    check({tag, "_mem_data"},   mem_data, 32'h0);
    check({tag, "_cpu_reset"},  32'(cpu_reset), 32'd1);
    check({tag, "_load_done"},  32'(load_done), 32'd0);
    check({tag, "_load_error"}, 32'(load_error), 32'd0);
    check({tag, "_words"},      32'(words_loaded), 32'd0);
  endtask

  task automatic idle(input int k);
    byte_valid = 1'b0;
    byte_data  = 8'h5A;
    repeat (k) @(negedge clock);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (byte_ready !== 1'b1 && guard < 16) begin
      @(negedge clock);
      guard++;
    end
    if (guard == 16) begin
      check("byte_ready_wait", 32'(byte_ready), 32'd1);
    end else begin
      @(negedge clock);
      csum = csum ^ b;
    end
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int b = 3; b >= 0; b--) send_byte(w[8*b +: 8]);
  endtask

  task automatic do_reset(input bit check_vals);
    @(negedge clock);
    reset      = 1'b0;
    byte_valid = 1'b0;
    #1;
    if (check_vals) check_reset_values("rst");
    @(negedge clock);
    reset = 1'b1;
    wr_addr.delete();
    wr_data.delete();
    csum = 8'h00;
    @(negedge clock);
    if (check_vals) check("rst_release_ready", 32'(byte_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   n_wr;
    csum = 8'h00;

    vecs[0] = '{name: "two_words", n: 16'd2, w0: 32'h3401_0001, w1: 32'h0022_1820,
                csum_flip: 8'h00, exp_done: 1'b1, exp_err: 1'b0, exp_words: 2};
    vecs[1] = '{name: "empty",     n: 16'd0, w0: 32'h0, w1: 32'h0,
                csum_flip: 8'h00, exp_done: 1'b1, exp_err: 1'b0, exp_words: 0};
    vecs[2] = '{name: "bad_csum",  n: 16'd1, w0: 32'hDEAD_BEEF, w1: 32'h0,
                csum_flip: 8'h01, exp_done: 1'b0, exp_err: 1'b1, exp_words: 1};
    vecs[3] = '{name: "oversize",  n: 16'(MAX_WORDS + 1), w0: 32'h0, w1: 32'h0,
                csum_flip: 8'h00, exp_done: 1'b0, exp_err: 1'b1, exp_words: 0};

    for (int i = 0; i < 4; i++) begin
      v = vecs[i];
      do_reset(i == 0);
      send_byte(v.n[15:8]);
      send_byte(v.n[7:0]);
      if (v.n > 16'(MAX_WORDS)) begin
        check({v.name, "_err_after_hdr"}, 32'(load_error), 32'd1);
        check({v.name, "_ready_after_hdr"}, 32'(byte_ready), 32'd0);
      end else begin
        if (v.n >= 16'd1) send_word(v.w0);
        if (v.n >= 16'd2) send_word(v.w1);
        send_byte(csum ^ v.csum_flip);
        check({v.name, "_done_next_cycle"}, 32'(load_done), 32'(v.exp_done));
      end
      idle(2);
      check({v.name, "_done"},       32'(load_done), 32'(v.exp_done));
      check({v.name, "_error"},      32'(load_error), 32'(v.exp_err));
      check({v.name, "_cpu_reset"},  32'(cpu_reset), 32'(!v.exp_done));
      check({v.name, "_byte_ready"}, 32'(byte_ready), 32'd0);
      check({v.name, "_words"},      32'(words_loaded), 32'(v.exp_words));
      check({v.name, "_writes"},     32'(wr_addr.size()), 32'(v.exp_words));
      for (int k = 0; k < wr_addr.size() && k < 2; k++) begin
        check({v.name, "_wr_addr"}, wr_addr[k], 32'(4 * k));
        check({v.name, "_wr_data"}, wr_data[k], (k == 0) ? v.w0 : v.w1);
      end
      // Bytes offered in a terminal state must be ignored.
      n_wr       = wr_addr.size();
      byte_valid = 1'b1;
      byte_data  = 8'hFF;
      repeat (3) @(negedge clock);
      byte_valid = 1'b0;
      check({v.name, "_term_ready"},  32'(byte_ready), 32'd0);
      check({v.name, "_term_writes"}, 32'(wr_addr.size()), 32'(n_wr));
      check({v.name, "_term_done"},   32'(load_done), 32'(v.exp_done));
    end

    // Header exactly MAX_WORDS is accepted and enters data phase.
    do_reset(1'b0);
    send_byte(8'h04);
    send_byte(8'h00);
    check("max_words_no_err", 32'(load_error), 32'd0);
    check("max_words_ready",  32'(byte_ready), 32'd1);

    // byte_valid gaps inside a word.
    do_reset(1'b0);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h11);
    idle(2);
    send_byte(8'h22);
    idle(1);
    send_byte(8'h33);
    check("gap_no_early_write", 32'(wr_addr.size()), 32'd0);
    check("gap_words_before",   32'(words_loaded), 32'd0);
    send_byte(8'h44);
    check("gap_we_pulse",       32'(mem_write_enable), 32'd1);
    check("gap_words_after",    32'(words_loaded), 32'd1);
    send_byte(csum);
    idle(2);
    check("gap_writes", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() >= 1) begin
      check("gap_wr_addr", wr_addr[0], 32'h0);
      check("gap_wr_data", wr_data[0], 32'h1122_3344);
    end
    check("gap_done", 32'(load_done), 32'd1);

    // Asynchronous reset in the middle of the second word, then a fresh image.
    do_reset(1'b0);
    send_byte(8'h00);
    send_byte(8'h02);
    send_word(32'hA1B2_C3D4);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    check("abort_words_before", 32'(words_loaded), 32'd1);
    #2 reset = 1'b0;
    #1 check_reset_values("async");
    @(negedge clock);
    reset = 1'b1;
    wr_addr.delete();
    wr_data.delete();
    csum = 8'h00;
    @(negedge clock);
    check("abort_ready", 32'(byte_ready), 32'd1);
    send_byte(8'h00);
    send_byte(8'h01);
    send_word(32'hCAFE_F00D);
    send_byte(csum);
    idle(2);
    check("abort_writes", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() >= 1) begin
      check("abort_wr_addr", wr_addr[0], 32'h0);
      check("abort_wr_data", wr_data[0], 32'hCAFE_F00D);
    end
    check("abort_done",      32'(load_done), 32'd1);
    check("abort_cpu_reset", 32'(cpu_reset), 32'd0);
    check("abort_words",     32'(words_loaded), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
